// File: rtl/mips_exec_unit_if.sv
// Bundle for the execute/load-align unit: the decoded-instruction inputs from the
// CPU and the registered results returned one clock later.
interface mips_exec_unit_if;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [5:0]  rtype_fncode;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] readdata_eb;
  logic [31:0] rt_val;
  logic [1:0]  lsb_bits;
  logic        out_valid;
  logic [5:0]  alu_fncode;
  logic [31:0] alu_out;
  logic [31:0] bytes_out;
  logic [3:0]  byteenable;

  // CPU side: drives operands, consumes results
  modport master (
    output in_valid, opcode, rtype_fncode, a, b, readdata_eb, rt_val, lsb_bits,
    input  out_valid, alu_fncode, alu_out, bytes_out, byteenable
  );

  // Execute unit side
  modport slave (
    input  in_valid, opcode, rtype_fncode, a, b, readdata_eb, rt_val, lsb_bits,
    output out_valid, alu_fncode, alu_out, bytes_out, byteenable
  );
endinterface

// File: rtl/mips_exec_unit.sv
// Registered execute/load-align unit: ALU-control decode, 32-bit ALU and load
// byte-lane handling (sub-word extract, LWL/LWR merge, byteenable). 1-cycle latency.
module mips_exec_unit (
  input  logic             clk,
  input  logic             reset,
  mips_exec_unit_if.slave  bus
);

  logic [5:0]  fn_d;
  logic [31:0] alu_d;
  logic [31:0] bytes_d;
  logic [3:0]  be_d;

  // ALU control: R-type passes supported functs, I-types map to their R-type op,
  // branches use the target adder (3F), everything else is an address add (21).
  always_comb begin
    fn_d = 6'h21;
    if (bus.opcode == 6'h00) begin
      case (bus.rtype_fncode)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B: fn_d = bus.rtype_fncode;
        default:      fn_d = 6'h21;
      endcase
    end else begin
      case (bus.opcode)
        6'h09:                             fn_d = 6'h21;
        6'h0A:                             fn_d = 6'h2A;
        6'h0B:                             fn_d = 6'h2B;
        6'h0C:                             fn_d = 6'h24;
        6'h0D:                             fn_d = 6'h25;
        6'h0E:                             fn_d = 6'h26;
        6'h0F:                             fn_d = 6'h0F;
        6'h01, 6'h04, 6'h05, 6'h06, 6'h07: fn_d = 6'h3F;
        default:                           fn_d = 6'h21;
      endcase
    end
  end

  // ALU: shift amount always comes from a[4:0], shifted value from b
  always_comb begin
    alu_d = 32'h0;
    case (fn_d)
      6'h00, 6'h04: alu_d = bus.b << bus.a[4:0];
      6'h02, 6'h06: alu_d = bus.b >> bus.a[4:0];
      6'h03, 6'h07: alu_d = $signed(bus.b) >>> bus.a[4:0];
      6'h21:        alu_d = bus.a + bus.b;
      6'h23:        alu_d = bus.a - bus.b;
      6'h24:        alu_d = bus.a & bus.b;
      6'h25:        alu_d = bus.a | bus.b;
      6'h26:        alu_d = bus.a ^ bus.b;
      6'h27:        alu_d = ~(bus.a | bus.b);
      6'h2A:        alu_d = ($signed(bus.a) < $signed(bus.b)) ? 32'd1 : 32'd0;
      6'h2B:        alu_d = (bus.a < bus.b) ? 32'd1 : 32'd0;
      6'h0F:        alu_d = {bus.b[15:0], 16'h0};
      6'h3F:        alu_d = bus.b + {bus.a[29:0], 2'b00};
      default:      alu_d = 32'h0;
    endcase
  end

  // Load lanes. The word is byte-swapped, so offset k sits at bit 8*(3-k) and
  // 3-k is simply ~lsb_bits on two bits.
  logic [4:0]  lo_k;
  logic [4:0]  sh_l;
  logic [7:0]  byte_k;
  logic [15:0] half_k;
  assign lo_k   = {~bus.lsb_bits, 3'b000};
  assign sh_l   = {bus.lsb_bits, 3'b000};
  assign byte_k = bus.readdata_eb[lo_k +: 8];
  assign half_k = bus.lsb_bits[1] ? bus.readdata_eb[15:0] : bus.readdata_eb[31:16];

  // Sub-word extract / merge and lane enables for the load opcode
  always_comb begin
    bytes_d = bus.readdata_eb;
    be_d    = 4'b1111;
    case (bus.opcode)
      6'h20: begin
        bytes_d = {{24{byte_k[7]}}, byte_k};
        be_d    = 4'b0001 << bus.lsb_bits;
      end
      6'h24: begin
        bytes_d = {24'h0, byte_k};
        be_d    = 4'b0001 << bus.lsb_bits;
      end
      6'h21: begin
        bytes_d = {{16{half_k[15]}}, half_k};
        be_d    = bus.lsb_bits[1] ? 4'b1100 : 4'b0011;
      end
      6'h25: begin
        bytes_d = {16'h0, half_k};
        be_d    = bus.lsb_bits[1] ? 4'b1100 : 4'b0011;
      end
      // LWL: upper lanes from memory, low 8k bits kept from rt
      6'h22: begin
        bytes_d = (bus.readdata_eb << sh_l) | (bus.rt_val & ~(32'hFFFFFFFF << sh_l));
        be_d    = 4'b1111 << bus.lsb_bits;
      end
      // LWR: low lanes from memory, upper bits kept from rt
      6'h26: begin
        bytes_d = (bus.readdata_eb >> lo_k) | (bus.rt_val & ~(32'hFFFFFFFF >> lo_k));
        be_d    = 4'b1111 >> (~bus.lsb_bits);
      end
      default: begin
        bytes_d = bus.readdata_eb;
        be_d    = 4'b1111;
      end
    endcase
  end

  // Output register: reset clears everything; idle cycles drop valid but hold data
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.alu_fncode <= 6'h0;
      bus.alu_out    <= 32'h0;
      bus.bytes_out  <= 32'h0;
      bus.byteenable <= 4'h0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.alu_fncode <= fn_d;
        bus.alu_out    <= alu_d;
        bus.bytes_out  <= bytes_d;
        bus.byteenable <= be_d;
      end
    end
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Bench for mips_exec_unit: directed table, reset/hold sequences, random vs model.
module tb_mips_exec_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_exec_unit_if bus ();
  mips_exec_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic        ov;
    logic [5:0]  fn;
    logic [31:0] alu;
    logic [31:0] bytes;
    logic [3:0]  be;
  } out_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic [31:0] rt;
    logic [1:0]  lsb;
    out_t        exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic drive(input logic iv, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd,
                       input logic [31:0] rt, input logic [1:0] lsb);
    bus.in_valid = iv; bus.opcode = op; bus.rtype_fncode = fn;
    bus.a = a; bus.b = b; bus.readdata_eb = rd; bus.rt_val = rt; bus.lsb_bits = lsb;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = '{bus.out_valid, bus.alu_fncode, bus.alu_out, bus.bytes_out, bus.byteenable};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ov=%0d fn=%h alu=%h bytes=%h be=%b, want ov=%0d fn=%h alu=%h bytes=%h be=%b",
               name, act.ov, act.fn, act.alu, act.bytes, act.be,
               exp.ov, exp.fn, exp.alu, exp.bytes, exp.be);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: decode table, arithmetic ALU, byte-array load handling
  function automatic out_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] rd, input logic [31:0] rt,
                                 input logic [1:0] lsb);
    out_t r;
    logic [5:0] c;
    logic [7:0] bk [4];
    logic [15:0] h;
    logic [63:0] mask;
    int k, j, s;
    r.ov = 1'b1;
    if (op == 6'h00)
      c = (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
                      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}) ? fn : 6'h21;
    else if (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) c = 6'h3F;
    else if (op == 6'h09) c = 6'h21;
    else if (op == 6'h0A) c = 6'h2A;
    else if (op == 6'h0B) c = 6'h2B;
    else if (op == 6'h0C) c = 6'h24;
    else if (op == 6'h0D) c = 6'h25;
    else if (op == 6'h0E) c = 6'h26;
    else if (op == 6'h0F) c = 6'h0F;
    else c = 6'h21;
    r.fn = c;
    s = int'(a[4:0]);
    if (c == 6'h00 || c == 6'h04)      r.alu = b << s;
    else if (c == 6'h02 || c == 6'h06) r.alu = b >> s;
    else if (c == 6'h03 || c == 6'h07) r.alu = 32'($signed(b) >>> s);
    else if (c == 6'h21) r.alu = 32'(64'(a) + 64'(b));
    else if (c == 6'h23) r.alu = 32'(64'(a) - 64'(b));
    else if (c == 6'h24) r.alu = a & b;
    else if (c == 6'h25) r.alu = a | b;
    else if (c == 6'h26) r.alu = a ^ b;
    else if (c == 6'h27) r.alu = ~(a | b);
    else if (c == 6'h2A) r.alu = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
    else if (c == 6'h2B) r.alu = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
    else if (c == 6'h0F) r.alu = b[15:0] * 32'h10000;
    else r.alu = 32'(64'(b) + 64'(a) * 4);

    for (int i = 0; i < 4; i++) bk[i] = rd[31-8*i -: 8];
    k = int'(lsb);
    j = lsb[1] ? 2 : 0;
    h = {bk[j], bk[j+1]};
    r.bytes = rd;
    r.be = 4'b1111;
    case (op)
      6'h20: begin r.bytes = {{24{bk[k][7]}}, bk[k]}; r.be = 4'h0; r.be[k] = 1'b1; end
      6'h24: begin r.bytes = {24'h0, bk[k]};           r.be = 4'h0; r.be[k] = 1'b1; end
      6'h21: begin r.bytes = {{16{h[15]}}, h}; r.be = (j == 2) ? 4'b1100 : 4'b0011; end
      6'h25: begin r.bytes = {16'h0, h};       r.be = (j == 2) ? 4'b1100 : 4'b0011; end
      6'h22: begin
        mask = (64'd1 << (8*k)) - 64'd1;
        r.bytes = 32'((64'(rd) << (8*k)) | (64'(rt) & mask));
        r.be = 4'h0;
        for (int i = k; i < 4; i++) r.be[i] = 1'b1;
      end
      6'h26: begin
        s = 8 * (3 - k);
        r.bytes = (rd >> s) | (rt & ~(32'hFFFFFFFF >> s));
        r.be = 4'h0;
        for (int i = 0; i <= k; i++) r.be[i] = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  vec_t tbl [20];
  logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h04, 6'h09, 6'h0A, 6'h0B,
                           6'h0C, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h22, 6'h25, 6'h26};
  logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h21,
                           6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h20};

  initial begin
    out_t zero, mexp;
    logic [5:0] op, fn;
    logic iv, rst;
    zero = '0;

    tbl[0]  = '{6'h00, 6'h21, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h21, 32'h00000001, 32'h0, 4'hF}};
    tbl[1]  = '{6'h00, 6'h03, 32'h4, 32'h80000000, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h03, 32'hF8000000, 32'h0, 4'hF}};
    tbl[2]  = '{6'h00, 6'h04, 32'h24, 32'h1, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h04, 32'h00000010, 32'h0, 4'hF}};
    tbl[3]  = '{6'h0A, 6'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h2A, 32'h1, 32'h0, 4'hF}};
    tbl[4]  = '{6'h0B, 6'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h2B, 32'h0, 32'h0, 4'hF}};
    tbl[5]  = '{6'h0F, 6'h00, 32'h0, 32'h0000ABCD, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h0F, 32'hABCD0000, 32'h0, 4'hF}};
    tbl[6]  = '{6'h04, 6'h00, 32'hFFFFFFFF, 32'hBFC00008, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h3F, 32'hBFC00004, 32'h0, 4'hF}};
    tbl[7]  = '{6'h20, 6'h00, 32'h0, 32'h0, 32'h11823344, 32'h0, 2'd1, '{1'b1, 6'h21, 32'h0, 32'hFFFFFF82, 4'b0010}};
    tbl[8]  = '{6'h24, 6'h00, 32'h0, 32'h0, 32'h11823344, 32'h0, 2'd1, '{1'b1, 6'h21, 32'h0, 32'h00000082, 4'b0010}};
    tbl[9]  = '{6'h21, 6'h00, 32'h0, 32'h0, 32'h11823344, 32'h0, 2'd2, '{1'b1, 6'h21, 32'h0, 32'h00003344, 4'b1100}};
    tbl[10] = '{6'h22, 6'h00, 32'h0, 32'h0, 32'hAABBCCDD, 32'h11223344, 2'd1, '{1'b1, 6'h21, 32'h0, 32'hBBCCDD44, 4'b1110}};
    tbl[11] = '{6'h26, 6'h00, 32'h0, 32'h0, 32'hAABBCCDD, 32'h11223344, 2'd1, '{1'b1, 6'h21, 32'h0, 32'h1122AABB, 4'b0011}};
    tbl[12] = '{6'h00, 6'h08, 32'h5, 32'h7, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h21, 32'hC, 32'h0, 4'hF}};
    tbl[13] = '{6'h23, 6'h00, 32'h100, 32'h4, 32'h12345678, 32'h0, 2'd3, '{1'b1, 6'h21, 32'h104, 32'h12345678, 4'hF}};
    tbl[14] = '{6'h21, 6'h00, 32'h0, 32'h0, 32'h80FF1234, 32'h0, 2'd1, '{1'b1, 6'h21, 32'h0, 32'hFFFF80FF, 4'b0011}};
    tbl[15] = '{6'h25, 6'h00, 32'h0, 32'h0, 32'h80FF1234, 32'h0, 2'd1, '{1'b1, 6'h21, 32'h0, 32'h000080FF, 4'b0011}};
    tbl[16] = '{6'h00, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h27, 32'h00000F0F, 32'h0, 4'hF}};
    tbl[17] = '{6'h00, 6'h22, 32'h5, 32'h3, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h21, 32'h8, 32'h0, 4'hF}};
    tbl[18] = '{6'h00, 6'h2A, 32'h80000000, 32'h1, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h2A, 32'h1, 32'h0, 4'hF}};
    tbl[19] = '{6'h00, 6'h02, 32'hFFFFFFE4, 32'h80000000, 32'h0, 32'h0, 2'd0, '{1'b1, 6'h02, 32'h08000000, 32'h0, 4'hF}};

    // Reset state
    reset = 1'b1;
    drive(1'b0, 6'h0, 6'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    tick(); tick();
    check("reset_state", zero);
    reset = 1'b0;

    // Directed table, each result one clock after in_valid
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].rt, tbl[i].lsb);
      tick();
      check($sformatf("tbl[%0d]", i), tbl[i].exp);
    end

    // Idle cycle: valid drops, data holds the last result
    mexp = tbl[19].exp;
    mexp.ov = 1'b0;
    drive(1'b0, 6'h20, 6'h21, 32'h1234, 32'h5678, 32'hDEADBEEF, 32'h0, 2'd2);
    tick();
    check("idle_hold", mexp);
    tick();
    check("idle_hold2", mexp);

    // Reset together with in_valid wins
    reset = 1'b1;
    drive(1'b1, 6'h00, 6'h21, 32'hFFFFFFFF, 32'h2, 32'h11111111, 32'h0, 2'd0);
    tick();
    check("reset_vs_valid", zero);
    reset = 1'b0;

    // Pending result discarded by reset on the following edge
    tick();
    check("valid_after_reset", tbl[0].exp | out_t'({1'b0, 6'h0, 32'h0, 32'h11111111, 4'h0}));
    drive(1'b1, 6'h0F, 6'h0, 32'h0, 32'h0000BEEF, 32'h0, 32'h0, 2'd0);
    reset = 1'b1;
    tick();
    check("reset_discard", zero);
    reset = 1'b0;
    drive(1'b0, 6'h0, 6'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    tick();
    check("post_reset_idle", zero);

    // Random traffic against the model
    mexp = zero;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
      fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
      reset = rst;
      drive(iv, op, fn, $urandom, $urandom, $urandom, $urandom, 2'($urandom));
      if (rst)     mexp = zero;
      else if (iv) mexp = model(op, fn, bus.a, bus.b, bus.readdata_eb, bus.rt_val, bus.lsb_bits);
      else         mexp.ov = 1'b0;
      tick();
      check($sformatf("rand[%0d] op=%h fn=%h", n, op, fn), mexp);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
